// File: rtl/mod_counter_sequencer.sv
// mod_counter_sequencer
// Steps a 32-bit MOD counter through a programmed table of phases. Each phase
// loads its own MOD and preload values and runs for a set number of rollovers.
// A schedule can optionally loop back to phase 0 after its last phase.
// Build option: define SEQ_TIMEOUT_EN to give up on a counter that does not
// acknowledge Start/Stop through its Running flag within ACK_TIMEOUT cycles.
module mod_counter_sequencer #(
   parameter int NUM_PHASES   = 4,
   parameter int REPEAT_WIDTH = 16,
   parameter int ACK_TIMEOUT  = 8,
   localparam int IDX_W       = $clog2(NUM_PHASES)
) (
   input  logic                    Clk_In,
   input  logic                    Reset_n_In,
   input  logic                    Cfg_Write_In,
   input  logic [IDX_W-1:0]        Cfg_Index_In,
   input  logic [31:0]             Cfg_MOD_Value_In,
   input  logic [31:0]             Cfg_Preload_In,
   input  logic [REPEAT_WIDTH-1:0] Cfg_Repeat_In,
   input  logic [IDX_W-1:0]        Last_Phase_In,
   input  logic                    Loop_In,
   input  logic                    Go_In,
   input  logic                    Abort_In,
   input  logic                    Counter_Running_Flag_In,
   input  logic                    Counter_Rollover_Flag_In,
   output logic                    Counter_Enable_Out,
   output logic                    Start_Counter_Command_Out,
   output logic                    Stop_Counter_Command_Out,
   output logic                    Load_Counter_Value_Command_Out,
   output logic [31:0]             Preload_Counter_Value_Out,
   output logic [31:0]             MOD_Value_Out,
   output logic                    Busy_Out,
   output logic [IDX_W-1:0]        Phase_Index_Out,
   output logic                    Phase_Done_Out,
   output logic                    Sequence_Done_Out,
   output logic                    Error_Out
);

   // Reject parameter sets the phase indexing and timeout logic cannot handle
   if ((NUM_PHASES < 2) || (NUM_PHASES > 16) ||
       ((NUM_PHASES & (NUM_PHASES - 1)) != 0) || (ACK_TIMEOUT < 1)) begin : g_param_check
      $error("mod_counter_sequencer: unsupported parameter set");
   end

   typedef enum logic [2:0] {
      IDLE, LOAD, START, WAIT_RUN, RUN, STOP, WAIT_STOP, NEXT
   } state_t;

   state_t                  state;
   logic [IDX_W-1:0]        last_phase;
   logic                    loop_en;
   logic [REPEAT_WIDTH-1:0] roll_cnt;

   logic [31:0]             mod_tab [NUM_PHASES];
   logic [31:0]             pre_tab [NUM_PHASES];
   logic [REPEAT_WIDTH-1:0] rep_tab [NUM_PHASES];

   logic [31:0]             cur_mod;
   logic [31:0]             cur_pre;
   logic [REPEAT_WIDTH-1:0] cur_rep;
   logic                    cur_valid;

`ifdef SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
   logic [TO_W-1:0] wait_cnt;
`endif

   assign cur_mod   = mod_tab[Phase_Index_Out];
   assign cur_pre   = pre_tab[Phase_Index_Out];
   assign cur_rep   = rep_tab[Phase_Index_Out];
   assign cur_valid = (cur_mod >= 32'd2) && (cur_rep != '0);

   // Phase table: only written while the sequencer is idle and not winding down
   always_ff @(posedge Clk_In or negedge Reset_n_In) begin
      if (!Reset_n_In) begin
         for (int i = 0; i < NUM_PHASES; i++) begin
            mod_tab[i] <= '0;
            pre_tab[i] <= '0;
            rep_tab[i] <= '0;
         end
      end else if (Cfg_Write_In && (state == IDLE) && !Busy_Out) begin
         mod_tab[Cfg_Index_In] <= Cfg_MOD_Value_In;
         pre_tab[Cfg_Index_In] <= Cfg_Preload_In;
         rep_tab[Cfg_Index_In] <= Cfg_Repeat_In;
      end
   end

   // Sequencer FSM; every command and status output is registered here
   always_ff @(posedge Clk_In or negedge Reset_n_In) begin
      if (!Reset_n_In) begin
         state                          <= IDLE;
         last_phase                     <= '0;
         loop_en                        <= 1'b0;
         roll_cnt                       <= '0;
         Counter_Enable_Out             <= 1'b0;
         Start_Counter_Command_Out      <= 1'b0;
         Stop_Counter_Command_Out       <= 1'b0;
         Load_Counter_Value_Command_Out <= 1'b0;
         Preload_Counter_Value_Out      <= '0;
         MOD_Value_Out                  <= '0;
         Busy_Out                       <= 1'b0;
         Phase_Index_Out                <= '0;
         Phase_Done_Out                 <= 1'b0;
         Sequence_Done_Out              <= 1'b0;
         Error_Out                      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
         wait_cnt                       <= '0;
`endif
      end else begin
         Start_Counter_Command_Out      <= 1'b0;
         Stop_Counter_Command_Out       <= 1'b0;
         Load_Counter_Value_Command_Out  <= 1'b0;
         Phase_Done_Out                 <= 1'b0;
         Sequence_Done_Out              <= 1'b0;

         if (Abort_In && (state != IDLE)) begin
            state <= IDLE;
            case (state)
               START, WAIT_RUN, RUN, STOP: Stop_Counter_Command_Out <= 1'b1;
               default:                    Busy_Out <= 1'b0;
            endcase
         end else begin
            case (state)
               IDLE: begin
                  Busy_Out <= 1'b0;
                  if (Go_In && !Abort_In && !Busy_Out) begin
                     last_phase         <= Last_Phase_In;
                     loop_en            <= Loop_In;
                     Phase_Index_Out    <= '0;
                     Busy_Out           <= 1'b1;
                     Counter_Enable_Out <= 1'b1;
                     Error_Out          <= 1'b0;
                     state              <= LOAD;
                  end
               end
               LOAD: begin
                  if (cur_valid) begin
                     MOD_Value_Out                  <= cur_mod;
                     Preload_Counter_Value_Out      <= cur_pre;
                     Load_Counter_Value_Command_Out <= 1'b1;
                     state                          <= START;
                  end else begin
                     Error_Out <= 1'b1;
                     state     <= NEXT;
                  end
               end
               START: begin
                  Start_Counter_Command_Out <= 1'b1;
                  roll_cnt                  <= '0;
`ifdef SEQ_TIMEOUT_EN
                  wait_cnt                  <= '0;
`endif
                  state                     <= WAIT_RUN;
               end
               WAIT_RUN: begin
                  if (Counter_Running_Flag_In) begin
                     state <= RUN;
                  end
`ifdef SEQ_TIMEOUT_EN
                  else if (wait_cnt == TO_LAST) begin
                     Error_Out                <= 1'b1;
                     Stop_Counter_Command_Out <= 1'b1;
                     state                    <= IDLE;
                  end else begin
                     wait_cnt <= wait_cnt + TO_W'(1);
                  end
`endif
               end
               RUN: begin
                  if (Counter_Rollover_Flag_In) begin
                     if (roll_cnt == (cur_rep - REPEAT_WIDTH'(1))) begin
                        state <= STOP;
                     end else begin
                        roll_cnt <= roll_cnt + REPEAT_WIDTH'(1);
                     end
                  end
               end
               STOP: begin
                  Stop_Counter_Command_Out <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
                  wait_cnt                 <= '0;
`endif
                  state                    <= WAIT_STOP;
               end
               WAIT_STOP: begin
                  if (!Counter_Running_Flag_In) begin
                     Phase_Done_Out <= 1'b1;
                     state          <= NEXT;
                  end
`ifdef SEQ_TIMEOUT_EN
                  else if (wait_cnt == TO_LAST) begin
                     Error_Out                <= 1'b1;
                     Stop_Counter_Command_Out <= 1'b1;
                     state                    <= IDLE;
                  end else begin
                     wait_cnt <= wait_cnt + TO_W'(1);
                  end
`endif
               end
               NEXT: begin
                  if (Phase_Index_Out < last_phase) begin
                     Phase_Index_Out <= Phase_Index_Out + IDX_W'(1);
                     state           <= LOAD;
                  end else if (loop_en) begin
                     Phase_Index_Out <= '0;
                     state           <= LOAD;
                  end else begin
                     Sequence_Done_Out <= 1'b1;
                     Busy_Out          <= 1'b0;
                     state             <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/mod_counter_sequencer.md
Name: mod_counter_sequencer

Overview:
- Controller that sequences a 32-bit MOD counter through a programmed list of up to NUM_PHASES phases.
- Each phase has its own MOD value, preload value and rollover-repeat count.
- Drives the counter's Enable/Start/Stop/Load command inputs and watches its Running/Rollover flags.
- Sits between the register/config interface and the MOD counter instance; optional looping for periodic schedules.

Parameters:
- NUM_PHASES, 4, phase-table depth (power of 2, 2..16)
- REPEAT_WIDTH, 16, width of per-phase rollover repeat count
- ACK_TIMEOUT, 8, cycles to wait for a Running-flag change (only with SEQ_TIMEOUT_EN)

Ports:
- Clk_In  in  1  clock, all logic on posedge
- Reset_n_In  in  1  async active-low reset
- Cfg_Write_In  in  1  write phase entry at Cfg_Index_In
- Cfg_Index_In  in  log2(NUM_PHASES)  phase-table index
- Cfg_MOD_Value_In  in  32  phase MOD value
- Cfg_Preload_In  in  32  phase preload value
- Cfg_Repeat_In  in  REPEAT_WIDTH  rollovers before phase ends
- Last_Phase_In  in  log2(NUM_PHASES)  index of final phase, sampled on Go
- Loop_In  in  1  restart at phase 0 after last phase, sampled on Go
- Go_In  in  1  start sequence (level, acted on in IDLE)
- Abort_In  in  1  stop sequence immediately
- Counter_Running_Flag_In  in  1  from counter
- Counter_Rollover_Flag_In  in  1  from counter, one-cycle pulse
- Counter_Enable_Out  out  1  counter output enable
- Start_Counter_Command_Out  out  1  one-cycle pulse
- Stop_Counter_Command_Out  out  1  one-cycle pulse
- Load_Counter_Value_Command_Out  out  1  one-cycle pulse
- Preload_Counter_Value_Out  out  32  current phase preload
- MOD_Value_Out  out  32  current phase MOD value
- Busy_Out  out  1  sequence active
- Phase_Index_Out  out  log2(NUM_PHASES)  current phase
- Phase_Done_Out  out  1  one-cycle pulse at end of each phase
- Sequence_Done_Out  out  1  one-cycle pulse on completion (not on abort)
- Error_Out  out  1  sticky; cleared on next accepted Go

Behaviour:
- Reset: all outputs 0. Phase table cleared to 0. FSM in IDLE.
- Config writes: accepted only in IDLE. Writes while Busy_Out=1 are ignored.
- Phase entry is valid when MOD >= 2 and Repeat != 0. Invalid entries are skipped: go to NEXT, set Error_Out, no counter commands issued.
- Outputs are registered. Command pulses are asserted for exactly one cycle. Never more than one command is asserted per cycle.
- FSM states: IDLE, LOAD, START, WAIT_RUN, RUN, STOP, WAIT_STOP, NEXT.
  - IDLE: on Go_In=1, latch Last_Phase/Loop, set phase=0, Busy=1, Counter_Enable=1, clear Error_Out -> LOAD.
  - LOAD: drive MOD/Preload outputs from the table, pulse Load -> START. MOD/Preload outputs hold stable until the next LOAD.
  - START: pulse Start, clear the rollover counter -> WAIT_RUN.
  - WAIT_RUN: wait for Running_Flag_In=1 -> RUN.
  - RUN: increment the rollover counter on each Rollover_Flag_In pulse. When the count reaches Repeat -> STOP in the same cycle as the final rollover.
  - STOP: pulse Stop -> WAIT_STOP.
  - WAIT_STOP: wait for Running_Flag_In=0 -> NEXT, and pulse Phase_Done.
  - NEXT: if phase < Last_Phase, phase+1 -> LOAD. Otherwise, if Loop, phase=0 -> LOAD. Otherwise pulse Sequence_Done, clear Busy -> IDLE. Counter_Enable stays 1.
- Abort_In (any non-IDLE state, priority over everything):
  - If the counter is running or being started, pulse Stop, then -> IDLE.
  - Busy=0 the cycle after the Stop pulse. No Phase_Done or Sequence_Done pulses.
- Go_In while Busy is ignored. Go and Abort asserted together in IDLE: Abort wins, stay IDLE.
- Rollover pulses outside RUN are ignored.
- Repeat count of all-ones is legal (no wrap: the comparison is an equality before the increment).
- Reset mid-sequence: outputs go to 0 asynchronously. The counter is not sent a Stop; the integrator resets both blocks together.

Optional Feature:
- SEQ_TIMEOUT_EN defined:
  - WAIT_RUN and WAIT_STOP each carry a cycle counter.
  - If the flag is not seen within ACK_TIMEOUT cycles: set Error_Out, pulse Stop, -> IDLE, Busy=0.
- Not defined: both wait states wait indefinitely and no timeout logic is synthesised.

Test Plan:
- Program phase0 MOD=10, preload=5, repeat=2; Last_Phase=0; Go.
  - Required: Load, Start, 2 rollovers observed, Stop, then Phase_Done and Sequence_Done pulses.
  - Counter sees 5..9, 0..9; Busy returns to 0.
- Two phases (MOD=4/rep=1, MOD=6/rep=3), Loop=1, run 30 rollovers, then Abort.
  - Required: MOD_Value_Out alternates 4,6 per phase.
  - Abort gives a single Stop pulse, Busy=0, no Sequence_Done.
- Phase1 with MOD=1 between valid phases 0 and 2.
  - Required: phase1 skipped with zero commands issued, Error_Out=1, phase2 runs.
  - Next Go clears Error_Out.
- Cfg_Write during Busy with MOD=99.
  - Required: table unchanged; subsequent run uses the old value.
- Go and Abort together in IDLE.
  - Required: no commands, Busy stays 0.
- With SEQ_TIMEOUT_EN, Running_Flag_In held 0 after Start.
  - Required: after 8 cycles Error_Out=1, one Stop pulse, IDLE.
  - Without the macro: FSM remains in WAIT_RUN.
